uart_tx: RTL and testbench

UART transmit-side framer, the counterpart of the RX parity-check/deserialize path. It accepts a parallel word with a valid strobe and serializes it onto TX_OUT:
- start bit (0)
- data LSB first
- optional parity bit, even or odd
- stop bit (1)

CLK runs at the bit rate, so one bit is sent per CLK cycle. The parity convention matches the RX checker: PAR_TYP=0 even, 1 odd.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_tx_serializer.sv | 37 +++
 rtl/uart_tx.sv | 124 ++++++++++++
 tb/tb_uart_tx.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX framer and the RX checker:
// FSM state encoding, parity selectors and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-word handshake and serial line of the UART transmitter.
// The master presents words; the slave (uart_tx) returns TX_OUT and Busy.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Load/shift register plus bit counter for the UART transmitter.
// cur_bit is the next data bit to put on the line; last_bit flags bit DATA_WIDTH-1.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift,
    input  logic                  advance,
    output logic                  cur_bit,
    output logic                  last_bit
);
    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         bit_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= load_data;
            bit_cnt <= '0;
        end else begin
            if (shift)
                shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
            if (advance)
                bit_cnt <= bit_cnt + CW'(1);
        end
    end

    assign cur_bit  = shreg[0];
    assign last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));
endmodule

// File: rtl/uart_tx.sv
// UART transmit framer: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN for a two-cycle stop bit.
//
// state  | meaning
// IDLE   | line high, Busy low, waiting for Data_Valid
// START  | start bit on the line
// DATA   | data bit bit_cnt on the line
// PARITY | latched parity bit on the line
// STOP   | stop bit on the line (two cycles with UART_TX_TWO_STOP_EN)
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_tx_if.slave bus
);
    uart_tx_state_t state;
    logic           tx_out_q;
    logic           busy_q;
    logic           par_en_q;
    logic           par_bit_q;
    logic           par_calc;
    logic           ser_load;
    logic           ser_shift;
    logic           ser_advance;
    logic           ser_bit;
    logic           ser_last;
`ifdef UART_TX_TWO_STOP_EN
    logic           stop_cnt;
`endif

    assign par_calc    = (bus.PAR_TYP == PAR_ODD) ? ~^bus.P_DATA : ^bus.P_DATA;
    assign ser_load    = (state == IDLE) && bus.Data_Valid;
    // START already emits bit 0, so the shifter moves there but the counter does not.
    assign ser_shift   = (state == START) || ((state == DATA) && !ser_last);
    assign ser_advance = (state == DATA) && !ser_last;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (ser_load),
        .load_data (bus.P_DATA),
        .shift     (ser_shift),
        .advance   (ser_advance),
        .cur_bit   (ser_bit),
        .last_bit  (ser_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            tx_out_q  <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Data_Valid) begin
                        par_en_q  <= bus.PAR_EN;
                        par_bit_q <= par_calc;
                        tx_out_q  <= START_BIT;
                        busy_q    <= 1'b1;
                        state     <= START;
                    end else begin
                        tx_out_q  <= IDLE_LEVEL;
                        busy_q    <= 1'b0;
                    end
                end
                START: begin
                    tx_out_q <= ser_bit;
                    state    <= DATA;
                end
                DATA: begin
                    if (!ser_last) begin
                        tx_out_q <= ser_bit;
                    end else if (par_en_q) begin
                        tx_out_q <= par_bit_q;
                        state    <= PARITY;
                    end else begin
                        tx_out_q <= STOP_BIT;
                        state    <= STOP;
                    end
                end
                PARITY: begin
                    tx_out_q <= STOP_BIT;
                    state    <= STOP;
                end
                STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                    if (!stop_cnt) begin
                        stop_cnt <= 1'b1;
                        tx_out_q <= STOP_BIT;
                    end else begin
                        stop_cnt <= 1'b0;
                        tx_out_q <= IDLE_LEVEL;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
`else
                    tx_out_q <= IDLE_LEVEL;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
`endif
                end
                default: begin
                    tx_out_q <= IDLE_LEVEL;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.TX_OUT = tx_out_q;
    assign bus.Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of frames plus hand-written corner sequences,
// expected line/busy values queued per cycle and compared at the falling edge.
module tb_uart_tx;
    localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int N_STOP = 2;
`else
    localparam int N_STOP = 1;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic tx;
        logic busy;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic       exp_par;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_cycle(input logic tx, input logic busy);
        exp_t e;
        e.tx   = tx;
        e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic push_frame(input logic [7:0] d, input logic pe, input logic par);
        push_cycle(1'b0, 1'b1);
        for (int i = 0; i < DW; i++)
            push_cycle(d[i], 1'b1);
        if (pe)
            push_cycle(par, 1'b1);
        for (int i = 0; i < N_STOP; i++)
            push_cycle(1'b1, 1'b1);
    endtask

    function automatic int frame_len(input logic pe);
        return 1 + DW + (pe ? 1 : 0) + N_STOP;
    endfunction

    task automatic drain(input int n, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL %s[%0d]: scoreboard empty, got tx=%0b busy=%0b", tag, i,
                         bus.TX_OUT, bus.Busy);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s_tx[%0d]", tag, i), 32'(bus.TX_OUT), 32'(e.tx));
                check($sformatf("%s_busy[%0d]", tag, i), 32'(bus.Busy), 32'(e.busy));
            end
        end
    endtask

    // Drive one accepted word, then scramble the inputs so any late sampling shows up.
    task automatic accept(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge CLK);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = ~d;
        bus.PAR_EN     = ~pe;
        bus.PAR_TYP    = ~pt;
    endtask

    initial begin
        int len;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{8'hA5, 1'b0, 1'b1, 1'b0};

        #12;
        check("rst_tx", 32'(bus.TX_OUT), 32'd1);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        push_cycle(1'b1, 1'b0);
        push_cycle(1'b1, 1'b0);
        drain(2, "idle");

        for (int v = 0; v < 7; v++) begin
            accept(vecs[v].data, vecs[v].pe, vecs[v].pt);
            push_frame(vecs[v].data, vecs[v].pe, vecs[v].exp_par);
            push_cycle(1'b1, 1'b0);
            drain(frame_len(vecs[v].pe) + 1, $sformatf("vec%0d", v));
        end

        // Data_Valid pulse mid-frame with new data and flipped parity type is ignored.
        len = frame_len(1'b1);
        accept(8'h3C, 1'b1, 1'b0);
        push_frame(8'h3C, 1'b1, 1'b0);
        push_cycle(1'b1, 1'b0);
        push_cycle(1'b1, 1'b0);
        drain(4, "ign");
        bus.P_DATA     = 8'hC3;
        bus.PAR_TYP    = ~bus.PAR_TYP;
        bus.Data_Valid = 1'b1;
        drain(1, "ign_pulse");
        bus.Data_Valid = 1'b0;
        drain(len + 2 - 5, "ign_tail");

        // Data_Valid held high: exactly one idle cycle between the two frames.
        len = frame_len(1'b0);
        @(negedge CLK);
        bus.P_DATA     = 8'h55;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.P_DATA = 8'h0F;
        push_frame(8'h55, 1'b0, 1'b0);
        push_cycle(1'b1, 1'b0);
        push_frame(8'h0F, 1'b0, 1'b0);
        drain(len + 2, "b2b");
        bus.Data_Valid = 1'b0;
        push_cycle(1'b1, 1'b0);
        drain(len, "b2b_tail");

        // Asynchronous reset while data bit 3 of 0xA5 (a zero) is on the line.
        accept(8'hA5, 1'b0, 1'b0);
        push_cycle(1'b0, 1'b1);
        push_cycle(1'b1, 1'b1);
        push_cycle(1'b0, 1'b1);
        push_cycle(1'b1, 1'b1);
        push_cycle(1'b0, 1'b1);
        drain(5, "pre_rst");
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_tx", 32'(bus.TX_OUT), 32'd1);
        check("async_rst_busy", 32'(bus.Busy), 32'd0);
        @(negedge CLK);
        check("rst_hold_tx", 32'(bus.TX_OUT), 32'd1);
        check("rst_hold_busy", 32'(bus.Busy), 32'd0);
        RST = 1'b1;
        push_cycle(1'b1, 1'b0);
        push_cycle(1'b1, 1'b0);
        drain(2, "post_rst");
        accept(8'h81, 1'b1, 1'b1);
        push_frame(8'h81, 1'b1, 1'b1);
        push_cycle(1'b1, 1'b0);
        drain(frame_len(1'b1) + 1, "after_rst");

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
